serial_subtractor_4bit: RTL and testbench
=========================================

SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits. Only 4 is verified; other widths are legal.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port start, input, 1: request a subtraction; sampled on the clk rising edge.
REQ-005 Port A, input, WIDTH: minuend (unsigned), sampled with start.
REQ-006 Port B, input, WIDTH: subtrahend (unsigned), sampled with start.
REQ-007 Port busy, output, 1: high while an operation is in progress.
REQ-008 Port done, output, 1: one-cycle pulse when the result becomes valid.
REQ-009 Port D, output, WIDTH+1: result. D[WIDTH-1:0] is the difference A-B mod 2^WIDTH. D[WIDTH] is the final borrow (1 when A<B).

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 In IDLE or DONE, start=1 at a rising edge SHALL:
 - capture A and B into internal shift registers;
 - clear the borrow flop and the bit counter;
 - enter RUN.
REQ-012 In RUN, each rising edge SHALL process one bit, LSB first:
 - diff = a^b^bin;
 - bout = (~a&b) | (~(a^b)&bin);
 - shift diff into the result register;
 - store bout in the borrow flop;
 - increment the counter.
REQ-013 After the WIDTH-th RUN edge, the FSM SHALL enter DONE.
 - D SHALL be updated with {borrow, difference} at that same edge.
REQ-014 Latency: if start is sampled at edge N, then done=1 and D is valid during the cycle after edge N+WIDTH. done SHALL fall at edge N+WIDTH+1.
REQ-015 busy SHALL be 1 exactly while the state is RUN.
REQ-016 done SHALL be 1 exactly while the state is DONE.
REQ-017 D SHALL hold its last result until the next DONE entry. D SHALL NOT change during RUN.
REQ-018 start while in RUN SHALL be ignored. Operands and progress are unaffected.
REQ-019 From DONE: start=1 SHALL give RUN (back-to-back operations, no idle gap); start=0 SHALL give IDLE.
REQ-020 Changes on A and B outside the start-sampling edge SHALL NOT affect the result.

Reset
REQ-021 rst_n=0 SHALL immediately force the following, regardless of clk:
 - state IDLE;
 - busy=0, done=0, D=0;
 - borrow flop, counter and shift registers cleared.
REQ-022 Reset asserted mid-RUN SHALL abandon the operation. No done pulse SHALL follow.
REQ-023 The first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-024 Macro SERIAL_SUB_OVF_EN defined:
 - output port ovf, 1 bit, is present;
 - ovf is the signed two's-complement overflow of A-B, i.e. (a_msb != b_msb) && (diff_msb != a_msb);
 - ovf updates and holds exactly like D;
 - ovf resets to 0.
REQ-025 Macro SERIAL_SUB_OVF_EN undefined: port ovf and all of its logic SHALL be absent. All other behaviour is identical.

Structure
REQ-026 Package serial_sub_pkg SHALL hold:
 - the state typedef (IDLE/RUN/DONE);
 - the default WIDTH constant.
REQ-027 Sub-module full_subtractor SHALL implement the one-bit cell from REQ-012:
 - inputs A, B, Bin;
 - outputs D, Bout;
 - instantiated once.

Verification
REQ-028 Reset then 5-3: start with A=0101, B=0011. Expected: done 4 cycles later, D=00010, busy high for 4 cycles.
REQ-029 3-5: A=0011, B=0101. Expected: D=11110 (borrow=1). 0-1 expected: D=11111. 15-15 expected: D=00000.
REQ-030 Back-to-back: start held high through DONE with A=1000, B=1111 and then A=1111, B=0001. Expected:
 - first D=11001;
 - the second operation starts with no IDLE cycle;
 - second D=01110.
REQ-031 Robustness: pulse start again mid-RUN and toggle A/B during RUN. Expected: the result still equals the originally captured operands.
REQ-032 Reset mid-op: drop rst_n 2 cycles into RUN. Expected:
 - busy=0, D=0, no done pulse;
 - the next start with A=0111, B=0010 gives D=00101.
REQ-033 With SERIAL_SUB_OVF_EN: A=1000, B=0001 expected ovf=1, D=00111. A=0101, B=0011 expected ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t    : FSM state encoding (IDLE / RUN / DONE)
//   DEF_WIDTH  : default operand width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell.
//   A, B  : minuend / subtrahend bits
//   Bin   : borrow in
//   D     : difference bit  (A ^ B ^ Bin)
//   Bout  : borrow out
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial unsigned subtractor: D = {borrow, A - B}, one bit per clock, LSB first.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request; A/B captured when sampled high in IDLE or DONE
//   A, B   : WIDTH-bit operands
//   busy   : high while the FSM is in RUN
//   done   : high for the single DONE cycle
//   D      : WIDTH+1 result {final borrow, difference}, held until the next DONE
//   ovf    : signed overflow of A-B (present only when SERIAL_SUB_OVF_EN is defined)
// Optional feature macro: SERIAL_SUB_OVF_EN
module serial_subtractor_4bit #(
  parameter int unsigned WIDTH = serial_sub_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH:0]   D
);

  import serial_sub_pkg::*;

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
  logic [CW-1:0]    cnt_q;
  logic             brw_q;
  logic             fs_d, fs_bout;
  logic             last_bit;
  logic             capture;

  full_subtractor u_fs (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (brw_q),
    .D    (fs_d),
    .Bout (fs_bout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  // start is honoured only outside RUN, so mid-operation pulses are ignored
  assign capture  = start && (state_q != RUN);
  // new difference bit enters at the MSB; after WIDTH shifts the word is aligned
  assign res_next = WIDTH'({fs_d, res_q} >> 1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath: operand shifters, borrow flop, bit counter, result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      brw_q <= 1'b0;
      cnt_q <= '0;
      D     <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (capture) begin
      a_q   <= A;
      b_q   <= B;
      brw_q <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      res_q <= res_next;
      brw_q <= fs_bout;
      cnt_q <= cnt_q + CW'(1);
      if (last_bit) begin
        D   <= {fs_bout, res_next};
`ifdef SERIAL_SUB_OVF_EN
        // on the last bit a_q[0]/b_q[0] are the operand MSBs and fs_d is the result MSB
        ovf <= (a_q[0] != b_q[0]) && (fs_d != a_q[0]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed self-checking bench for serial_subtractor_4bit.
module tb_serial_subtractor_4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A, B;
  logic       busy, done;
  logic [4:0] D;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int unsigned n_assert;
  int unsigned n_fail;
  logic [4:0]  prev_d;

  serial_subtractor_4bit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .D     (D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
`ifdef SERIAL_SUB_OVF_EN
    chk(tag, {31'd0, ovf}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  // One full operation with start as a single-cycle pulse; checks RUN, DONE and the cycle after.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] exp_d, input logic exp_o, input string tag);
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      chk({tag, "_dhold"}, {27'd0, D}, {27'd0, prev_d});
      tick();
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_idlebusy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_d"}, {27'd0, D}, {27'd0, exp_d});
    chk_ovf({tag, "_ovf"}, exp_o);
    tick();
    chk({tag, "_donefall"}, {31'd0, done}, 32'd0);
    chk({tag, "_dafter"}, {27'd0, D}, {27'd0, exp_d});
    prev_d = exp_d;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    prev_d   = 5'd0;
    rst_n = 1'b0; start = 1'b0; A = 4'd0; B = 4'd0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_d", {27'd0, D}, 32'd0);
    chk_ovf("rst_ovf", 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    run_op(4'b0101, 4'b0011, 5'b00010, 1'b0, "s5m3");
    run_op(4'b0011, 4'b0101, 5'b11110, 1'b0, "s3m5");
    run_op(4'b0000, 4'b0001, 5'b11111, 1'b0, "s0m1");
    run_op(4'b1111, 4'b1111, 5'b00000, 1'b0, "s15m15");
    run_op(4'b1000, 4'b0001, 5'b00111, 1'b1, "s8m1");

    // back-to-back: start held high, second operands presented during the first RUN
    A = 4'b1000; B = 4'b1111; start = 1'b1;
    tick();
    A = 4'b1111; B = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_busy1", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk("b2b_d1", {27'd0, D}, {27'd0, 5'b11001});
    chk_ovf("b2b_ovf1", 1'b0);
    tick();
    start = 1'b0;
    chk("b2b_norest", {31'd0, busy}, 32'd1);
    chk("b2b_dhold", {27'd0, D}, {27'd0, 5'b11001});
    tick(); tick(); tick();
    chk("b2b_busy2", {31'd0, busy}, 32'd1);
    tick();
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk("b2b_d2", {27'd0, D}, {27'd0, 5'b01110});
    chk_ovf("b2b_ovf2", 1'b0);
    tick();
    chk("b2b_idle", {31'd0, done | busy}, 32'd0);
    prev_d = 5'b01110;

    // robustness: start pulses and operand toggling during RUN are ignored
    A = 4'b1010; B = 4'b0100; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      A = 4'($urandom); B = 4'($urandom); start = (i % 2 == 0);
      chk("rob_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    start = 1'b0;
    chk("rob_done", {31'd0, done}, 32'd1);
    chk("rob_d", {27'd0, D}, {27'd0, 5'b00110});
    chk_ovf("rob_ovf", 1'b1);
    tick();
    chk("rob_idle", {31'd0, busy | done}, 32'd0);

    // reset two cycles into RUN
    A = 4'b1100; B = 4'b0001; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_d", {27'd0, D}, 32'd0);
    chk_ovf("mrst_ovf", 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_nodone", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("mrst_stillidle", {31'd0, done | busy}, 32'd0);
    prev_d = 5'd0;
    run_op(4'b0111, 4'b0010, 5'b00101, 1'b0, "s7m2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
